// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the Baccarat dealing stage.
// Latency: none (types, constants and pure functions only).
// Backpressure: n/a.
package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1,
    DEAL_D1,
    DEAL_P2,
    DEAL_D2,
    EVAL,
    DEAL_P3,
    EVAL_B,
    DEAL_D3,
    DONE
  } state_e;

  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_A     = 4'd1;
  localparam logic [3:0] CARD_10    = 4'd10;
  localparam logic [3:0] CARD_J     = 4'd11;
  localparam logic [3:0] CARD_Q     = 4'd12;
  localparam logic [3:0] CARD_K     = 4'd13;

  // Pips count at face value; blank, tens and court cards count zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    if (code >= CARD_A && code < CARD_10) begin
      return code;
    end
    return 4'd0;
  endfunction

  // Hand total mod 10; max sum is 27 so two conditional subtracts suffice.
  function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                            input logic [3:0] c2,
                                            input logic [3:0] c3);
    logic [4:0] s;
    s = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end
    if (s >= 5'd10) begin
      s = s - 5'd10;
    end
    return s[3:0];
  endfunction

endpackage

// File: rtl/baccarat_dealer_dealcard.sv
// Free-running 1..13 card counter acting as the shuffled-deck source.
// Latency: new_card is the registered count, advancing every edge.
// Backpressure: none; the counter never stalls.
module dealcard (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] new_card
);

  logic [3:0] new_card_q;
  logic [3:0] new_card_d;

  // Next count: wrap king back to ace.
  always_comb begin
    new_card_d = new_card_q + 4'd1;
    if (new_card_q == 4'd13) begin
      new_card_d = 4'd1;
    end
  end

  // Count register; reset starts the deck at ace.
  always_ff @(posedge clk) begin
    if (reset) begin
      new_card_q <= 4'd1;
    end else begin
      new_card_q <= new_card_d;
    end
  end

  assign new_card = new_card_q;

endmodule

// File: rtl/baccarat_dealer.sv
// Deals a Punto Banco hand into six card slots and reports scores/winner.
// Latency: a card lands on the edge sampling deal; EVAL/EVAL_B add one cycle each.
// Backpressure: deal is dropped outside dealing states; no queuing.
module baccarat_dealer
  import baccarat_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       deal,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       done,
  output logic       player_win,
  output logic       dealer_win
);

  logic [3:0] new_card;
  state_e     state_q, state_d;
  logic [3:0] pcard1_q, pcard1_d, pcard2_q, pcard2_d, pcard3_q, pcard3_d;
  logic [3:0] dcard1_q, dcard1_d, dcard2_q, dcard2_d, dcard3_q, dcard3_d;
  logic       done_q, done_d;
  logic [3:0] p3_value;
  logic       banker_draws;
  logic       natural;

  dealcard u_dealcard (
    .clk      (clk),
    .reset    (reset),
    .new_card (new_card)
  );

  assign pscore   = hand_score(pcard1_q, pcard2_q, pcard3_q);
  assign dscore   = hand_score(dcard1_q, dcard2_q, dcard3_q);
  assign natural  = (pscore >= 4'd8) || (dscore >= 4'd8);
  assign p3_value = card_value(pcard3_q);

  // Banker third-card table, keyed on banker score and player's third card.
  always_comb begin
    banker_draws = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: banker_draws = 1'b1;
      4'd3:             banker_draws = (p3_value != 4'd8);
      4'd4:             banker_draws = (p3_value >= 4'd2) && (p3_value <= 4'd7);
      4'd5:             banker_draws = (p3_value >= 4'd4) && (p3_value <= 4'd7);
      4'd6:             banker_draws = (p3_value >= 4'd6) && (p3_value <= 4'd7);
      default:          banker_draws = 1'b0;
    endcase
  end

  // Hand sequencer: load the sampled card into the current slot and branch.
  always_comb begin
    state_d  = state_q;
    pcard1_d = pcard1_q;
    pcard2_d = pcard2_q;
    pcard3_d = pcard3_q;
    dcard1_d = dcard1_q;
    dcard2_d = dcard2_q;
    dcard3_d = dcard3_q;
    case (state_q)
      DEAL_P1: if (deal) begin pcard1_d = new_card; state_d = DEAL_D1; end
      DEAL_D1: if (deal) begin dcard1_d = new_card; state_d = DEAL_P2; end
      DEAL_P2: if (deal) begin pcard2_d = new_card; state_d = DEAL_D2; end
      DEAL_D2: if (deal) begin dcard2_d = new_card; state_d = EVAL;    end
      EVAL: begin
        if (natural) begin
          state_d = DONE;
        end else if (pscore <= 4'd5) begin
          state_d = DEAL_P3;
        end else if (dscore <= 4'd5) begin
          state_d = DEAL_D3;
        end else begin
          state_d = DONE;
        end
      end
      DEAL_P3: if (deal) begin pcard3_d = new_card; state_d = EVAL_B; end
      EVAL_B:  state_d = banker_draws ? DEAL_D3 : DONE;
      DEAL_D3: if (deal) begin dcard3_d = new_card; state_d = DONE;   end
      DONE:    state_d = DONE;
      default: state_d = DEAL_P1;
    endcase
    done_d = (state_d == DONE);
  end

  // State and slot registers; reset clears the table and overrides deal.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= DEAL_P1;
      pcard1_q <= CARD_EMPTY;
      pcard2_q <= CARD_EMPTY;
      pcard3_q <= CARD_EMPTY;
      dcard1_q <= CARD_EMPTY;
      dcard2_q <= CARD_EMPTY;
      dcard3_q <= CARD_EMPTY;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcard1_q <= pcard1_d;
      pcard2_q <= pcard2_d;
      pcard3_q <= pcard3_d;
      dcard1_q <= dcard1_d;
      dcard2_q <= dcard2_d;
      dcard3_q <= dcard3_d;
      done_q   <= done_d;
    end
  end

  assign pcard1     = pcard1_q;
  assign pcard2     = pcard2_q;
  assign pcard3     = pcard3_q;
  assign dcard1     = dcard1_q;
  assign dcard2     = dcard2_q;
  assign dcard3     = dcard3_q;
  assign done       = done_q;
  assign player_win = done_q && (pscore >= dscore);
  assign dealer_win = done_q && (dscore >= pscore);

endmodule

// File: tb/tb_baccarat_dealer.sv
// Self-checking bench for baccarat_dealer: scripted hands with a card scoreboard.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_baccarat_dealer;

  localparam int SL_NONE = 0;
  localparam int SL_P1 = 1;
  localparam int SL_D1 = 2;
  localparam int SL_P2 = 3;
  localparam int SL_D2 = 4;
  localparam int SL_P3 = 5;
  localparam int SL_D3 = 6;

  typedef struct {
    int         slot;
    logic [3:0] code;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       deal = 1'b0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       done, player_win, dealer_win;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cnt_m = 1;
  exp_t sbq[$];

  baccarat_dealer dut (
    .clk        (clk),
    .reset      (reset),
    .deal       (deal),
    .pcard1     (pcard1),
    .pcard2     (pcard2),
    .pcard3     (pcard3),
    .dcard1     (dcard1),
    .dcard2     (dcard2),
    .dcard3     (dcard3),
    .pscore     (pscore),
    .dscore     (dscore),
    .done       (done),
    .player_win (player_win),
    .dealer_win (dealer_win)
  );

  always #5 clk = ~clk;

  // Reference deck counter: value before an edge is the card dealt on it.
  always @(posedge clk) begin
    if (reset) cnt_m = 1;
    else cnt_m = (cnt_m == 13) ? 1 : cnt_m + 1;
  end

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_val(input int s);
    case (s)
      SL_P1:   return int'(pcard1);
      SL_D1:   return int'(dcard1);
      SL_P2:   return int'(pcard2);
      SL_D2:   return int'(dcard2);
      SL_P3:   return int'(pcard3);
      SL_D3:   return int'(dcard3);
      default: return -1;
    endcase
  endfunction

  task automatic pop_chk();
    exp_t e;
    e = sbq.pop_front();
    if (e.slot != SL_NONE) chk_eq($sformatf("slot%0d", e.slot), slot_val(e.slot), int'(e.code));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    deal  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for the deck to show `want`, then deal it into `slot`.
  task automatic deal_into(input int slot, input int want);
    int waited;
    waited = 0;
    deal = 1'b0;
    while (cnt_m != want && waited < 14) begin
      tick();
      waited++;
    end
    if (cnt_m != want) chk_eq("deck_wait", cnt_m, want);
    sbq.push_back('{slot, 4'(want)});
    deal = 1'b1;
    tick();
    deal = 1'b0;
    pop_chk();
  endtask

  task automatic chk_hand(input string tag, input int p1, input int p2, input int p3,
                          input int d1, input int d2, input int d3);
    chk_eq({tag, "_p1"}, pcard1, p1);
    chk_eq({tag, "_p2"}, pcard2, p2);
    chk_eq({tag, "_p3"}, pcard3, p3);
    chk_eq({tag, "_d1"}, dcard1, d1);
    chk_eq({tag, "_d2"}, dcard2, d2);
    chk_eq({tag, "_d3"}, dcard3, d3);
  endtask

  task automatic chk_result(input string tag, input int dn, input int ps, input int ds,
                            input int pw, input int dw);
    chk_eq({tag, "_done"}, done, dn);
    chk_eq({tag, "_pscore"}, pscore, ps);
    chk_eq({tag, "_dscore"}, dscore, ds);
    chk_eq({tag, "_pwin"}, player_win, pw);
    chk_eq({tag, "_dwin"}, dealer_win, dw);
  endtask

  initial begin
    int slots[8];
    slots = '{SL_P1, SL_D1, SL_P2, SL_D2, SL_NONE, SL_P3, SL_NONE, SL_D3};

    // Reset state.
    do_reset();
    chk_hand("rst", 0, 0, 0, 0, 0, 0);
    chk_result("rst", 0, 0, 0, 0, 0);

    // Hand 1: deal held high from release; player draws, banker draws on 6/6.
    deal = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sbq.push_back('{slots[k], 4'(cnt_m)});
      tick();
      pop_chk();
      if (k == 3) chk_result("h1_two", 0, 4, 6, 0, 0);
      if (k == 6) chk_result("h1_evb", 0, 0, 6, 0, 0);
    end
    chk_hand("h1", 1, 3, 6, 2, 4, 8);
    chk_result("h1", 1, 0, 4, 0, 1);
    repeat (3) tick();
    chk_hand("h1_hold", 1, 3, 6, 2, 4, 8);
    chk_result("h1_hold", 1, 0, 4, 0, 1);
    deal = 1'b0;

    // Reset in DEAL_P3 with deal high: nothing loads, deck restarts at ace.
    do_reset();
    deal = 1'b1;
    repeat (5) tick();
    chk_eq("mid_p3_empty", pcard3, 0);
    reset = 1'b1;
    tick();
    chk_hand("mid_rst", 0, 0, 0, 0, 0, 0);
    chk_result("mid_rst", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    deal = 1'b0;
    chk_eq("mid_rst_first", pcard1, 1);
    chk_eq("mid_rst_d1", dcard1, 0);

    // Hand 2: player natural 9 ends the hand one cycle after dcard2.
    do_reset();
    deal_into(SL_P1, 4);
    deal_into(SL_D1, 2);
    deal_into(SL_P2, 5);
    deal_into(SL_D2, 1);
    chk_eq("h2_eval_done", done, 0);
    deal = 1'b1;
    tick();
    chk_result("h2", 1, 9, 3, 1, 0);
    repeat (2) tick();
    deal = 1'b0;
    chk_hand("h2", 4, 5, 0, 2, 1, 0);

    // Hand 3: both naturals 8 -> tie raises both flags.
    do_reset();
    deal_into(SL_P1, 13);
    deal_into(SL_D1, 10);
    deal_into(SL_P2, 8);
    deal_into(SL_D2, 8);
    tick();
    chk_result("h3", 1, 8, 8, 1, 1);
    chk_hand("h3", 13, 8, 0, 10, 8, 0);

    // Hand 4: player stands on 7, banker 3 draws directly; deal in EVAL dropped.
    do_reset();
    deal_into(SL_P1, 7);
    deal_into(SL_D1, 2);
    deal_into(SL_P2, 13);
    deal_into(SL_D2, 1);
    deal = 1'b1;
    tick();
    deal = 1'b0;
    chk_hand("h4_eval", 7, 13, 0, 2, 1, 0);
    chk_result("h4_eval", 0, 7, 3, 0, 0);
    deal_into(SL_D3, 5);
    chk_result("h4", 1, 7, 8, 0, 1);
    chk_eq("h4_p3_blank", pcard3, 0);

    // Deck wraps 13 -> 1: after 26 idle edges the next card is an ace again.
    do_reset();
    repeat (26) tick();
    chk_eq("wrap_idle_p1", pcard1, 0);
    sbq.push_back('{SL_P1, 4'd1});
    deal = 1'b1;
    tick();
    deal = 1'b0;
    pop_chk();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  // Absolute time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "time limit");
  end

endmodule
